// File: rtl/pulse_scheduler.sv
// rtl/pulse_scheduler.sv - round-robin shared programmable pulse-burst generator
module pulse_scheduler #(
  parameter int NREQ = 2,
  parameter int CW   = 8
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic [NREQ-1:0]   i_req,
  input  logic [NREQ*CW-1:0] i_high_cnt,
  input  logic [NREQ*CW-1:0] i_low_cnt,
  input  logic [NREQ*CW-1:0] i_num_pulses,
  output logic [NREQ-1:0]   o_grant,
  output logic              o_busy,
  output logic [NREQ-1:0]   o_done,
  output logic              o_signal
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_DONE} state_t;

  state_t          r_state;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_owner;
  logic [NREQ-1:0] r_grant;
  logic            r_busy;
  logic [NREQ-1:0] r_done;
  logic            r_signal;
  logic [CW-1:0]   r_high;
  logic [CW-1:0]   r_low;
  logic [CW-1:0]   r_num;
  logic [CW-1:0]   r_phase;
  logic [CW-1:0]   r_pulses;

  logic            w_found;
  logic [PW-1:0]   w_win;
  int              w_idx;
  int              w_sel;
  logic [NREQ-1:0] w_grant_vec;
  logic [CW-1:0]   w_high_eff;
  logic [CW-1:0]   w_low_eff;
  logic [PW-1:0]   w_ptr_next;

  // Round-robin search: first requesting index at or above the pointer, wrapping around
  always_comb begin
    w_found     = 1'b0;
    w_win       = '0;
    w_idx       = 0;
    w_sel       = 0;
    w_grant_vec = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_idx = int'(r_ptr) + i;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (!w_found && i_req[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
        w_win   = PW'(w_idx);
      end
    end
    if (w_found) w_grant_vec[w_sel] = 1'b1;
  end

  // A programmed count of zero behaves as one cycle; pointer moves just past the finished owner
  always_comb begin
    w_high_eff = (r_high == '0) ? CW'(1) : r_high;
    w_low_eff  = (r_low  == '0) ? CW'(1) : r_low;
    w_ptr_next = (r_owner == PW'(NREQ - 1)) ? '0 : r_owner + PW'(1);
  end

  // Burst FSM: arbitrate in IDLE, time HIGH/LOW phases, strobe done for one cycle in DONE
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_owner  <= '0;
      r_grant  <= '0;
      r_busy   <= 1'b0;
      r_done   <= '0;
      r_signal <= 1'b0;
      r_high   <= '0;
      r_low    <= '0;
      r_num    <= '0;
      r_phase  <= '0;
      r_pulses <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_owner  <= w_win;
            r_grant  <= w_grant_vec;
            r_busy   <= 1'b1;
            r_high   <= i_high_cnt[w_sel*CW +: CW];
            r_low    <= i_low_cnt[w_sel*CW +: CW];
            r_num    <= i_num_pulses[w_sel*CW +: CW];
            r_phase  <= CW'(1);
            r_pulses <= '0;
            if (i_num_pulses[w_sel*CW +: CW] == '0) begin
              r_state  <= S_DONE;
              r_done   <= w_grant_vec;
              r_signal <= 1'b0;
            end else begin
              r_state  <= S_HIGH;
              r_signal <= 1'b1;
            end
          end
        end
        S_HIGH: begin
          if (r_phase == w_high_eff) begin
            r_state  <= S_LOW;
            r_signal <= 1'b0;
            r_phase  <= CW'(1);
          end else begin
            r_phase <= r_phase + CW'(1);
          end
        end
        S_LOW: begin
          if (r_phase == w_low_eff) begin
            r_pulses <= r_pulses + CW'(1);
            r_phase  <= CW'(1);
            if ((r_pulses + CW'(1)) == r_num) begin
              r_state <= S_DONE;
              r_done  <= r_grant;
            end else begin
              r_state  <= S_HIGH;
              r_signal <= 1'b1;
            end
          end else begin
            r_phase <= r_phase + CW'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_grant <= '0;
          r_busy  <= 1'b0;
          r_done  <= '0;
          r_ptr   <= w_ptr_next;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_grant  = r_grant;
  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_signal = r_signal;

endmodule

// File: tb/tb_pulse_scheduler.sv
// tb/tb_pulse_scheduler.sv - table-driven and sequence checks for pulse_scheduler
module tb_pulse_scheduler;

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [7:0]  h0, l0, n0, h1, l1, n1;
  logic [1:0]  grant;
  logic        busy;
  logic [1:0]  done;
  logic        sig;

  int n_pass;
  int n_total;

  typedef struct {
    logic [1:0] req;
    logic [7:0] h0, l0, n0, h1, l1, n1;
    logic [5:0] exp;
  } vec_t;

  vec_t vq[$];
  logic [1:0] sq[$];

  pulse_scheduler #(.NREQ(2), .CW(8)) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_req        (req),
    .i_high_cnt   ({h1, h0}),
    .i_low_cnt    ({l1, l0}),
    .i_num_pulses ({n1, n0}),
    .o_grant      (grant),
    .o_busy       (busy),
    .o_done       (done),
    .o_signal     (sig)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] outs();
    return {grant, busy, done, sig};
  endfunction

  function automatic vec_t mk(input logic [1:0] r, input logic [7:0] a0, b0, c0, a1, b1, c1,
                              input logic [5:0] e);
    vec_t v;
    v.req = r; v.h0 = a0; v.l0 = b0; v.n0 = c0; v.h1 = a1; v.l1 = b1; v.n1 = c1; v.exp = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    chk("reset_state", {2'b0, outs()}, 8'h00);
    rst = 1'b0;
  endtask

  // expected {signal, done[0]} trace of one burst for requester 0
  task automatic push_burst(input int h, input int l, input int n);
    for (int p = 0; p < n; p++) begin
      for (int c = 0; c < h; c++) sq.push_back(2'b10);
      for (int c = 0; c < l; c++) sq.push_back(2'b00);
    end
    sq.push_back(2'b01);
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst = 1'b1; req = '0;
    h0 = '0; l0 = '0; n0 = '0; h1 = '0; l1 = '0; n1 = '0;

    // test 1: h=1,l=1,n=4 on requester 0 (req dropped after grant)
    vq.push_back(mk(2'b01, 1, 1, 4, 0, 0, 0, 6'b01_1_00_1));
    for (int i = 0; i < 7; i++)
      vq.push_back(mk(2'b00, 1, 1, 4, 0, 0, 0, (i % 2 == 0) ? 6'b01_1_00_0 : 6'b01_1_00_1));
    vq.push_back(mk(2'b00, 1, 1, 4, 0, 0, 0, 6'b01_1_01_0));
    vq.push_back(mk(2'b00, 1, 1, 4, 0, 0, 0, 6'b00_0_00_0));
    // test 3: zero pulses on requester 1
    vq.push_back(mk(2'b10, 0, 0, 0, 5, 5, 0, 6'b10_1_10_0));
    vq.push_back(mk(2'b00, 0, 0, 0, 5, 5, 0, 6'b00_0_00_0));
    vq.push_back(mk(2'b00, 0, 0, 0, 5, 5, 0, 6'b00_0_00_0));
    // test 4: zero high/low counts act as one
    vq.push_back(mk(2'b01, 0, 0, 2, 0, 0, 0, 6'b01_1_00_1));
    vq.push_back(mk(2'b00, 0, 0, 2, 0, 0, 0, 6'b01_1_00_0));
    vq.push_back(mk(2'b00, 0, 0, 2, 0, 0, 0, 6'b01_1_00_1));
    vq.push_back(mk(2'b00, 0, 0, 2, 0, 0, 0, 6'b01_1_00_0));
    vq.push_back(mk(2'b00, 0, 0, 2, 0, 0, 0, 6'b01_1_01_0));
    vq.push_back(mk(2'b00, 0, 0, 2, 0, 0, 0, 6'b00_0_00_0));

    do_reset();
    foreach (vq[i]) begin
      req = vq[i].req;
      h0 = vq[i].h0; l0 = vq[i].l0; n0 = vq[i].n0;
      h1 = vq[i].h1; l1 = vq[i].l1; n1 = vq[i].n1;
      tick();
      chk($sformatf("vec%0d", i), {2'b0, outs()}, {2'b0, vq[i].exp});
    end

    // test 2: both held, h=2 l=3 n=1 -> 01,10,01,10 with one idle cycle between
    req = 2'b00;
    h0 = 2; l0 = 3; n0 = 1; h1 = 2; l1 = 3; n1 = 1;
    do_reset();
    req = 2'b11;
    for (int b = 0; b < 4; b++) begin
      for (int j = 0; j < 7; j++) begin
        logic [1:0] g;
        logic [5:0] e;
        g = (b % 2 == 0) ? 2'b01 : 2'b10;
        if (j < 5)       e = {g, 1'b1, 2'b00, (j < 2) ? 1'b1 : 1'b0};
        else if (j == 5) e = {g, 1'b1, g, 1'b0};
        else             e = 6'b0;
        tick();
        chk($sformatf("rr_b%0d_c%0d", b, j), {2'b0, outs()}, {2'b0, e});
      end
    end

    // test 5: reset during 2nd HIGH of requester 1, pointer previously advanced to 1
    req = 2'b00;
    do_reset();
    req = 2'b01; h0 = 0; l0 = 0; n0 = 0;
    tick();
    chk("rst_pre_done0", {2'b0, outs()}, {2'b0, 6'b01_1_01_0});
    req = 2'b10; h1 = 2; l1 = 2; n1 = 4;
    tick();
    chk("rst_pre_idle", {2'b0, outs()}, 8'h00);
    tick(); chk("rst_h1a", {2'b0, outs()}, {2'b0, 6'b10_1_00_1});
    tick(); chk("rst_h1b", {2'b0, outs()}, {2'b0, 6'b10_1_00_1});
    tick(); chk("rst_l1a", {2'b0, outs()}, {2'b0, 6'b10_1_00_0});
    tick(); chk("rst_l1b", {2'b0, outs()}, {2'b0, 6'b10_1_00_0});
    tick(); chk("rst_h2a", {2'b0, outs()}, {2'b0, 6'b10_1_00_1});
    #2 rst = 1'b1;
    #1 chk("rst_async", {2'b0, outs()}, 8'h00);
    tick(); chk("rst_hold0", {2'b0, outs()}, 8'h00);
    tick(); chk("rst_hold1", {2'b0, outs()}, 8'h00);
    req = 2'b11; h0 = 1; l0 = 1; n0 = 1;
    rst = 1'b0;
    tick();
    chk("rst_ptr_grant", {2'b0, outs()}, {2'b0, 6'b01_1_00_1});

    // test 6: high_cnt[0] changed 3 -> 5 mid-burst; only the next burst sees 5
    req = 2'b00;
    do_reset();
    h0 = 3; l0 = 1; n0 = 2; req = 2'b01;
    push_burst(3, 1, 2);
    sq.push_back(2'b00);
    push_burst(5, 1, 2);
    foreach (sq[k]) begin
      tick();
      chk($sformatf("freeze_c%0d", k), {6'b0, sig, done[0]}, {6'b0, sq[k]});
      if (k == 1) h0 = 5;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
